// File: rtl/cpu_clk_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_clk_ctrl
//
// Clock-enable controller for the pipelined CPU. It sits downstream of the
// board clock divider. It turns the divided clock (tick_clk), a raw step
// push-button and a run switch into a single-clk-cycle enable pulse (cpu_ce)
// that advances the pipeline. The controller supports three modes:
//   - continuous run at the divided rate,
//   - one pipeline cycle per button press (step),
//   - stop while the pipeline requests a halt.
//
// Parameters
//   DB_CYCLES  consecutive stable clk cycles needed to accept a button change
//   CNT_W      width of cycle_count
//
// Ports
//   clk          in   fast board clock, rising-edge active
//   rst          in   asynchronous, active-low reset
//   tick_clk     in   divided clock, registered in the clk domain
//   step_btn     in   raw bouncy step button, active-high, asynchronous
//   run_sw       in   1 = continuous run, 0 = step mode
//   halt         in   pipeline halt request, level, synchronous to clk
//   cpu_ce       out  pipeline clock enable, one clk cycle wide
//   state        out  FSM state: 0 IDLE, 1 RUN, 2 STEP, 3 HALTED
//   cycle_count  out  number of cpu_ce pulses issued (wraps)
//
// Build option
//   CPU_CYCLE_COUNT_EN  when defined, the cycle_count register and its
//                       incrementer are built. When undefined, cycle_count
//                       is tied to 0. The cpu_ce and FSM behaviour is the
//                       same in both builds.
// -----------------------------------------------------------------------------
module cpu_clk_ctrl #(
  parameter int DB_CYCLES = 50000,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_clk,
  input  logic             step_btn,
  input  logic             run_sw,
  input  logic             halt,
  output logic             cpu_ce,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] cycle_count
);

  // Debounce counter only has to reach DB_CYCLES-1. Keep it at least 1 bit
  // wide so that DB_CYCLES=1 still elaborates.
  localparam int              DB_W   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_STEP   = 2'd2,
    S_HALTED = 2'd3
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic            tick_q,        tick_d;
  logic            sync1_q,       sync1_d;
  logic            sync2_q,       sync2_d;       // synchronised button (btn_s)
  logic [DB_W-1:0] db_cnt_q,      db_cnt_d;
  logic            btn_db_q,      btn_db_d;      // debounced button level
  logic            btn_db_prev_q, btn_db_prev_d; // btn_db delayed one cycle
  state_e          state_q,       state_d;
  logic            cpu_ce_q,      cpu_ce_d;

  logic            tick_rise;
  logic            press;

  // ---------------------------------------------------------------------------
  // Tick edge detect and button conditioning
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written in an always_comb gets a default value first.
    // If any path leaves one unassigned, synthesis infers a latch.
    tick_d        = tick_clk;
    sync1_d       = step_btn;
    sync2_d       = sync1_q;
    btn_db_d      = btn_db_q;
    db_cnt_d      = '0;
    btn_db_prev_d = btn_db_q;

    // tick_q resets high. A tick_clk that is already high when reset is
    // released is therefore not mistaken for a rising edge.
    tick_rise = tick_clk & ~tick_q;

    // The counter runs only while the synchronised level disagrees with the
    // accepted level. Any agreement, including a bounce back, restarts it.
    if (sync2_q != btn_db_q) begin
      if (db_cnt_q == DB_MAX) begin
        btn_db_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end

    press = btn_db_q & ~btn_db_prev_q;
  end

  // ---------------------------------------------------------------------------
  // Mode FSM and enable generation
  // halt wins over every other input in every state. cpu_ce is only ever
  // driven from a tick_rise. tick_rise needs tick_q low, so two pulses can
  // never land on adjacent cycles.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cpu_ce_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (halt) begin
          state_d = S_HALTED;
        end else if (run_sw) begin
          state_d = S_RUN;
        end else if (press) begin
          state_d = S_STEP;
        end
      end

      S_RUN: begin
        if (halt) begin
          state_d = S_HALTED;
        end else if (!run_sw) begin
          state_d = S_IDLE;
        end else begin
          cpu_ce_d = tick_rise;
        end
      end

      // Presses and run_sw are ignored here. A pending step completes on the
      // next tick edge, and a second press is not queued.
      S_STEP: begin
        if (halt) begin
          state_d = S_HALTED;
        end else if (tick_rise) begin
          cpu_ce_d = 1'b1;
          state_d  = S_IDLE;
        end
      end

      // Leave only once the halt is gone and the run switch is off. The CPU
      // therefore never restarts unexpectedly when a halt clears.
      S_HALTED: begin
        if (!halt && !run_sw) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_q        <= 1'b1;
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      db_cnt_q      <= '0;
      btn_db_q      <= 1'b0;
      btn_db_prev_q <= 1'b0;
      state_q       <= S_IDLE;
      cpu_ce_q      <= 1'b0;
    end else begin
      // NOTE: registers use non-blocking assignments. Every flop then samples
      // the pre-edge values, whatever the statement order.
      tick_q        <= tick_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      db_cnt_q      <= db_cnt_d;
      btn_db_q      <= btn_db_d;
      btn_db_prev_q <= btn_db_prev_d;
      state_q       <= state_d;
      cpu_ce_q      <= cpu_ce_d;
    end
  end

  assign cpu_ce = cpu_ce_q;
  assign state  = state_q;

  // ---------------------------------------------------------------------------
  // Optional cycle counter
  // The counter increments from cpu_ce_d, so it shows the post-increment
  // value in the same cycle that cpu_ce is high.
  // ---------------------------------------------------------------------------
`ifdef CPU_CYCLE_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (cpu_ce_d) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cycle_count = cnt_q;
`else
  assign cycle_count = '0;
`endif

endmodule

// File: doc/cpu_clk_ctrl.md
# cpu_clk_ctrl

Clock-enable controller that sits directly downstream of the board clock divider and feeds the pipelined CPU. It takes the divided slow clock (`tick_clk`), the fast board clock, a raw step push-button and a run switch, and produces a single-`clk`-cycle enable pulse `cpu_ce` that advances the pipeline. The pipeline then runs continuously at the divided rate, single-steps one instruction cycle per button press, or stops on a pipeline halt. An optional cycle counter reports how many pipeline cycles have been issued.

## Interface
- `DB_CYCLES`, default 50000: number of consecutive stable `clk` cycles required to accept a button level change.
- `CNT_W`, default 16: width of `cycle_count`.
- `clk`  in  1  fast board clock; all logic is clocked on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `tick_clk`  in  1  divided clock from the clock divider; same clock domain as `clk` (registered from it).
- `step_btn`  in  1  raw, bouncy step push-button, active-high, asynchronous.
- `run_sw`  in  1  1 selects continuous run; 0 selects step mode.
- `halt`  in  1  pipeline halt request, synchronous to `clk`, level.
- `cpu_ce`  out  1  pipeline clock enable, one `clk` cycle wide.
- `state`  out  2  FSM state: 0 IDLE, 1 RUN, 2 STEP, 3 HALTED.
- `cycle_count`  out  CNT_W  number of `cpu_ce` pulses issued.

## Operation
- **Tick edge detect:** register `tick_q <= tick_clk`. `tick_rise = tick_clk & ~tick_q`. `tick_q` resets to 1, so a high `tick_clk` at reset release is not treated as an edge.
- **Button path:** 2-flop synchronizer → `btn_s`. The debounce counter increments while `btn_s != btn_db`; it clears when they are equal. When the counter reaches `DB_CYCLES-1` with a mismatch, `btn_db <= btn_s` and the counter clears. `press = btn_db & ~btn_db_q`, one cycle wide.
- **FSM** (`halt` has priority over every other input in every state):
  - **IDLE:** if `halt`, go to HALTED. Else if `run_sw`, go to RUN. Else if `press`, go to STEP. Otherwise stay.
  - **RUN:** if `halt`, go to HALTED with no pulse. Else if `!run_sw`, go to IDLE with no pulse. Else `cpu_ce` follows `tick_rise`.
  - **STEP:** if `halt`, go to HALTED. Else on `tick_rise`, emit exactly one `cpu_ce` and go to IDLE. Further presses while in STEP are ignored, not queued. `run_sw` is ignored in STEP.
  - **HALTED:** no pulses. Go to IDLE only when `halt==0` and `run_sw==0`.
- **Counter:** `cycle_count` increments by 1 on every `cpu_ce` and wraps from all-ones to 0.
- **Reset:** asserting `rst` at any time, including mid-STEP, immediately forces:
  - state IDLE;
  - `cpu_ce=0`, `cycle_count=0`;
  - `btn_db=0`, debounce counter 0, synchronizer flops 0;
  - `tick_q=1`.
  
  A pending step is discarded.

## Timing
- `cpu_ce` is registered. If `tick_clk` is first sampled high at `clk` edge N, `cpu_ce` is high from edge N to edge N+1: one cycle of latency after the tick edge becomes visible, and exactly one cycle wide.
- At most one `cpu_ce` per `tick_clk` period. `cpu_ce` is never high on two consecutive cycles.
- Button latency: 2 synchronizer cycles plus `DB_CYCLES` cycles, then one cycle for `press`. The step pulse then waits for the next `tick_rise`, a worst case of one `tick_clk` period.
- The `state` output is registered and updates on the edge after the qualifying input.
- `cycle_count` updates on the same edge that `cpu_ce` is asserted, so it shows the post-increment value while `cpu_ce` is high.
- `halt` and `tick_rise` in the same cycle, in RUN or STEP: no pulse, next state HALTED.

## Configuration
- **`CPU_CYCLE_COUNT_EN` defined:** the `cycle_count` register and incrementer are built as described above.
- **Not defined:** no counter logic is built; `cycle_count` is tied to 0. The `cpu_ce` and FSM behaviour is identical in both builds.

## Test plan
Bench settings: `DB_CYCLES=4` and a `tick_clk` period of 200 `clk` cycles unless stated otherwise.

- **Reset:** `rst=0` with `tick_clk=1`, release → `cpu_ce=0`, `state=0`, `cycle_count=0`, and no pulse in the first 10 cycles.
- **Continuous run:** `run_sw=1` for 3 tick periods → state goes 0 to 1; 3 pulses, each 1 cycle wide, spaced 200 cycles apart, each one cycle after its `tick_rise`; `cycle_count=3`.
- **Single step:** `step_btn` bounces (toggling every 2 cycles for 12 cycles), then held high for 20 cycles → exactly one `cpu_ce` at the next `tick_rise`, then `state=0`. A second press while in STEP produces no extra pulse.
- **Halt priority:** in RUN, assert `halt` in the same cycle as `tick_rise`:
  - no pulse, `state=3`;
  - `halt=0` with `run_sw=1` → stays at 3;
  - `run_sw=0` → `state=0`.
- **Counter wrap** (`CNT_W=4`, `CPU_CYCLE_COUNT_EN` defined): 17 ticks in RUN → `cycle_count=1`. In the build without the macro, `cycle_count` stays 0.
- **Reset mid-step:** after `press` and before `tick_rise`, pulse `rst` low → immediately `state=0` and `cpu_ce=0`, and no pulse occurs on the following tick.
